exec_sequencer: RTL and testbench

Multi-cycle control sequencer for the accumulator core. It replaces the permanently enabled program counter with a FETCH/DECODE/EXEC/WB state machine that generates the program counter enable, instruction latch, accumulator write and register-file write strobes. It also adds fetch wait-states with a timeout, a sticky halt, debug single-step over a request/acknowledge pair, and a retired-instruction counter. It sits between the instruction decoder outputs and the pc/acc/reg_file enables.

---
 rtl/exec_sequencer_pkg.sv | 24 ++
 rtl/exec_sequencer_wait_timer.sv | 30 +++
 rtl/exec_sequencer.sv | 154 +++++++++++++++
 tb/tb_exec_sequencer.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/exec_sequencer_pkg.sv
// Purpose  : state encoding and shared helpers for the exec sequencer and its users.
// Latency  : n/a (declarations only).
// Backpressure: n/a.
package exec_sequencer_pkg;

    localparam int STATE_W = 3;

    // Encodings are fixed so decoder, debug logic and benches agree on the raw value.
    typedef enum logic [STATE_W-1:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_WB     = 3'd4,
        S_PAUSE  = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    // Busy covers the four instruction phases only.
    function automatic logic state_is_busy(input state_t s);
        return (s == S_FETCH) || (s == S_DECODE) || (s == S_EXEC) || (s == S_WB);
    endfunction

endpackage

// File: rtl/exec_sequencer_wait_timer.sv
// Purpose  : fetch wait-state counter; clr zeroes it, inc advances it, expired flags WAIT_MAX.
// Latency  : count updates on the clock after clr/inc; expired is combinational from the count.
// Backpressure: none; the counter holds at WAIT_MAX instead of wrapping.
// Ports    : clk, rst (async high), clr, inc -> expired.
module exec_sequencer_wait_timer #(
    parameter int WAIT_MAX = 15,
    parameter int CNT_W    = $clog2(WAIT_MAX + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic expired
);

    logic [CNT_W-1:0] cnt_q;

    assign expired = (cnt_q == CNT_W'(WAIT_MAX));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (inc && !expired) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/exec_sequencer.sv
// Purpose  : FETCH/DECODE/EXEC/WB sequencer driving pc/ir/acc/rf strobes, with halt, fetch timeout and debug step.
// Latency  : 4 cycles per instruction plus one per fetch wait cycle; strobes are combinational from state.
// Backpressure: mem_ready stalls FETCH; WAIT_MAX+1 consecutive stalls halt with a sticky fault.
// Ports    : run/dbg_mode/step_req/mem_ready/load_req/store_req/halt_req in;
//            pc_ce/ir_we/acc_we/rf_we/step_ack strobes, busy/halted/fault/state/instr_cnt status out.
module exec_sequencer
    import exec_sequencer_pkg::*;
#(
    parameter int ADDR_WIDTH  = 5,
    parameter int REG_BIT_CNT = 3,
    parameter int DATA_WIDTH  = 16,
    parameter int WAIT_MAX    = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  run,
    input  logic                  dbg_mode,
    input  logic                  step_req,
    input  logic                  mem_ready,
    input  logic                  load_req,
    input  logic                  store_req,
    input  logic                  halt_req,
    output logic                  pc_ce,
    output logic                  ir_we,
    output logic                  acc_we,
    output logic                  rf_we,
    output logic                  step_ack,
    output logic                  busy,
    output logic                  halted,
    output logic                  fault,
    output logic [STATE_W-1:0]    state,
    output logic [DATA_WIDTH-1:0] instr_cnt
);

    if (WAIT_MAX < 1 || ADDR_WIDTH < 1 || REG_BIT_CNT < 1 || DATA_WIDTH < 1) begin : g_param_check
        $error("exec_sequencer: WAIT_MAX, ADDR_WIDTH, REG_BIT_CNT and DATA_WIDTH must all be >= 1");
    end

    state_t state_q;
    state_t state_d;
    logic   step_q;
    logic   step_edge;
    logic   timer_clr;
    logic   timer_inc;
    logic   timer_expired;
    logic   fault_set;
    logic   retire;

    // step_q samples every cycle, so a request already high on entry to PAUSE is not a new step.
    assign step_edge = step_req & ~step_q;

    exec_sequencer_wait_timer #(
        .WAIT_MAX (WAIT_MAX)
    ) u_wait_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (timer_clr),
        .inc     (timer_inc),
        .expired (timer_expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            step_q    <= 1'b0;
            fault     <= 1'b0;
            instr_cnt <= '0;
        end else begin
            state_q <= state_d;
            step_q  <= step_req;
            if (fault_set) begin
                fault <= 1'b1;
            end
            if (retire && (instr_cnt != '1)) begin
                instr_cnt <= instr_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        ir_we     = 1'b0;
        acc_we    = 1'b0;
        rf_we     = 1'b0;
        pc_ce     = 1'b0;
        step_ack  = 1'b0;
        timer_clr = 1'b1;
        timer_inc = 1'b0;
        fault_set = 1'b0;
        retire    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (run) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                timer_clr = 1'b0;
                ir_we     = mem_ready;
                // A word arriving on the last allowed cycle still counts as a fetch.
                if (mem_ready) begin
                    timer_clr = 1'b1;
                    state_d   = S_DECODE;
                end else if (timer_expired) begin
                    fault_set = 1'b1;
                    state_d   = S_HALT;
                end else begin
                    timer_inc = 1'b1;
                end
            end
            S_DECODE: begin
                state_d = halt_req ? S_HALT : S_EXEC;
            end
            S_EXEC: begin
                acc_we  = load_req;
                state_d = S_WB;
            end
            S_WB: begin
                rf_we  = store_req;
                pc_ce  = 1'b1;
                retire = 1'b1;
                if (!run) begin
                    state_d = S_IDLE;
                end else if (dbg_mode) begin
                    state_d = S_PAUSE;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_PAUSE: begin
                // Dropping run wins; a step seen together with it is not acknowledged.
                if (!run) begin
                    state_d = S_IDLE;
                end else if (step_edge) begin
                    step_ack = 1'b1;
                    state_d  = S_FETCH;
                end else if (!dbg_mode) begin
                    state_d = S_FETCH;
                end
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign state  = state_q;
    assign busy   = state_is_busy(state_q);
    assign halted = (state_q == S_HALT);

endmodule

// File: tb/tb_exec_sequencer.sv
module tb_exec_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic run = 1'b0;
    logic dbg_mode = 1'b0;
    logic step_req = 1'b0;
    logic mem_ready = 1'b0;
    logic load_req = 1'b0;
    logic store_req = 1'b0;
    logic halt_req = 1'b0;

    logic        pc_ce, ir_we, acc_we, rf_we, step_ack, busy, halted, fault;
    logic [2:0]  state;
    logic [15:0] instr_cnt;

    // Second instance: narrow counter and shortest timeout for the boundary cases.
    logic        s_pc_ce, s_ir_we, s_acc_we, s_rf_we, s_step_ack, s_busy, s_halted, s_fault;
    logic [2:0]  s_state;
    logic [2:0]  s_instr_cnt;

    always #5 clk = ~clk;

    exec_sequencer #(
        .ADDR_WIDTH(5), .REG_BIT_CNT(3), .DATA_WIDTH(16), .WAIT_MAX(15)
    ) dut (
        .clk(clk), .rst(rst), .run(run), .dbg_mode(dbg_mode), .step_req(step_req),
        .mem_ready(mem_ready), .load_req(load_req), .store_req(store_req), .halt_req(halt_req),
        .pc_ce(pc_ce), .ir_we(ir_we), .acc_we(acc_we), .rf_we(rf_we), .step_ack(step_ack),
        .busy(busy), .halted(halted), .fault(fault), .state(state), .instr_cnt(instr_cnt)
    );

    exec_sequencer #(
        .ADDR_WIDTH(5), .REG_BIT_CNT(3), .DATA_WIDTH(3), .WAIT_MAX(1)
    ) dut_small (
        .clk(clk), .rst(rst), .run(run), .dbg_mode(dbg_mode), .step_req(step_req),
        .mem_ready(mem_ready), .load_req(load_req), .store_req(store_req), .halt_req(halt_req),
        .pc_ce(s_pc_ce), .ir_we(s_ir_we), .acc_we(s_acc_we), .rf_we(s_rf_we), .step_ack(s_step_ack),
        .busy(s_busy), .halted(s_halted), .fault(s_fault), .state(s_state), .instr_cnt(s_instr_cnt)
    );

    // in  = {rst, run, dbg_mode, step_req, mem_ready, load_req, store_req, halt_req}
    // o   = {ir_we, acc_we, rf_we, pc_ce, step_ack, busy, halted, fault}
    typedef struct {
        logic [7:0]  in;
        logic [2:0]  st;
        logic [7:0]  o;
        logic [15:0] cnt;
    } vec_t;

    localparam int NVEC = 16;
    vec_t tbl [NVEC];

    int passed = 0;
    int total  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end else begin
            passed++;
        end
    endtask

    function automatic logic [7:0] obs_strobes();
        return {ir_we, acc_we, rf_we, pc_ce, step_ack, busy, halted, fault};
    endfunction

    task automatic next();
        @(negedge clk);
    endtask

    task automatic do_reset();
        next();
        rst = 1'b1;
        {run, dbg_mode, step_req, mem_ready, load_req, store_req, halt_req} = '0;
        next();
        rst = 1'b0;
    endtask

    initial begin
        int strobes;
        int bad_state;
        int acks;
        int pcs;

        // Basic program, fetch wait states, then a halting instruction.
        tbl[0]  = '{8'b1000_0000, 3'd0, 8'b0000_0000, 16'd0}; // reset
        tbl[1]  = '{8'b0100_1110, 3'd0, 8'b0000_0000, 16'd0}; // IDLE, run rises
        tbl[2]  = '{8'b0100_1110, 3'd1, 8'b1000_0100, 16'd0}; // FETCH  ir_we
        tbl[3]  = '{8'b0100_1110, 3'd2, 8'b0000_0100, 16'd0}; // DECODE
        tbl[4]  = '{8'b0100_1110, 3'd3, 8'b0100_0100, 16'd0}; // EXEC   acc_we
        tbl[5]  = '{8'b0100_1110, 3'd4, 8'b0011_0100, 16'd0}; // WB     rf_we pc_ce
        tbl[6]  = '{8'b0100_1110, 3'd1, 8'b1000_0100, 16'd1};
        tbl[7]  = '{8'b0100_1110, 3'd2, 8'b0000_0100, 16'd1};
        tbl[8]  = '{8'b0100_1110, 3'd3, 8'b0100_0100, 16'd1};
        tbl[9]  = '{8'b0100_1110, 3'd4, 8'b0011_0100, 16'd1};
        tbl[10] = '{8'b0100_0110, 3'd1, 8'b0000_0100, 16'd2}; // wait 1
        tbl[11] = '{8'b0100_0110, 3'd1, 8'b0000_0100, 16'd2}; // wait 2
        tbl[12] = '{8'b0100_0110, 3'd1, 8'b0000_0100, 16'd2}; // wait 3
        tbl[13] = '{8'b0100_1110, 3'd1, 8'b1000_0100, 16'd2}; // ready, ir_we 3 late
        tbl[14] = '{8'b0100_1111, 3'd2, 8'b0000_0100, 16'd2}; // DECODE with halt_req
        tbl[15] = '{8'b0100_1111, 3'd6, 8'b0000_0010, 16'd2}; // HALT, no strobes

        for (int i = 0; i < NVEC; i++) begin
            next();
            {rst, run, dbg_mode, step_req, mem_ready, load_req, store_req, halt_req} = tbl[i].in;
            #1;
            chk($sformatf("vec%0d_state_strobes", i), {21'd0, state, obs_strobes()},
                {21'd0, tbl[i].st, tbl[i].o});
            chk($sformatf("vec%0d_instr_cnt", i), {16'd0, instr_cnt}, {16'd0, tbl[i].cnt});
        end

        // HALT is absorbing for 50 cycles with inputs still active.
        strobes = 0;
        bad_state = 0;
        mem_ready = 1'b1;
        for (int i = 0; i < 50; i++) begin
            next();
            #1;
            strobes += int'(ir_we) + int'(acc_we) + int'(rf_we) + int'(pc_ce) + int'(step_ack);
            if (state !== 3'd6) bad_state++;
        end
        chk("halt_hold_strobes", strobes, 0);
        chk("halt_hold_state", bad_state, 0);
        chk("halt_hold_cnt", {16'd0, instr_cnt}, 32'd2);

        next();
        rst = 1'b1;
        #1;
        chk("rst_from_halt", {21'd0, state, obs_strobes()}, 32'd0);
        chk("rst_from_halt_cnt", {16'd0, instr_cnt}, 32'd0);

        // Fetch timeout: 16 not-ready cycles halts with fault; small instance halts after 2.
        do_reset();
        run = 1'b1;
        next();            // FETCH cycle 1
        next();
        next();            // FETCH cycle 3
        #1;
        chk("small_timeout_state", {29'd0, s_state}, 32'd6);
        chk("small_timeout_fault", {31'd0, s_fault}, 32'd1);
        chk("main_no_early_fault", {31'd0, fault}, 32'd0);
        repeat (13) next(); // FETCH cycle 16
        #1;
        chk("fetch16_still_fetch", {21'd0, state, obs_strobes()}, {21'd0, 3'd1, 8'b0000_0100});
        next();
        #1;
        chk("timeout_halt", {21'd0, state, obs_strobes()}, {21'd0, 3'd6, 8'b0000_0011});
        mem_ready = 1'b1;
        load_req  = 1'b1;
        store_req = 1'b1;
        strobes = 0;
        for (int i = 0; i < 10; i++) begin
            next();
            #1;
            strobes += int'(ir_we) + int'(acc_we) + int'(rf_we) + int'(pc_ce);
        end
        chk("timeout_no_strobes", strobes, 0);

        // Ready on exactly the 16th cycle wins over the timeout.
        do_reset();
        run = 1'b1;
        next();
        repeat (15) next();
        mem_ready = 1'b1;
        #1;
        chk("ready16_ir_we", {31'd0, ir_we}, 32'd1);
        next();
        #1;
        chk("ready16_decode", {29'd0, state}, 32'd2);
        chk("ready16_no_fault", {31'd0, fault}, 32'd0);

        // Debug single step.
        do_reset();
        {run, dbg_mode, mem_ready, load_req, store_req} = 5'b11111;
        repeat (5) next();
        #1;
        chk("dbg_pause", {21'd0, state, obs_strobes()}, {21'd0, 3'd5, 8'b0000_0000});
        step_req = 1'b1;
        acks = 0;
        pcs = 0;
        for (int i = 0; i < 10; i++) begin
            #1;
            acks += int'(step_ack);
            pcs  += int'(pc_ce);
            next();
        end
        #1;
        chk("step_held_acks", acks, 1);
        chk("step_held_instrs", pcs, 1);
        chk("step_held_paused", {29'd0, state}, 32'd5);
        step_req = 1'b0;
        next();
        next();
        step_req = 1'b1;
        acks = 0;
        pcs = 0;
        for (int i = 0; i < 8; i++) begin
            #1;
            acks += int'(step_ack);
            pcs  += int'(pc_ce);
            next();
        end
        chk("step_again_acks", acks, 1);
        chk("step_again_instrs", pcs, 1);
        chk("step_cnt", {16'd0, instr_cnt}, 32'd3);
        dbg_mode = 1'b0;
        next();
        #1;
        chk("dbg_off_resumes", {29'd0, state}, 32'd1);

        // run=0 beats dbg_mode in WB; run dropped in EXEC finishes through WB.
        do_reset();
        {run, mem_ready, load_req, store_req} = 4'b1111;
        repeat (4) next();
        run = 1'b0;
        dbg_mode = 1'b1;
        #1;
        chk("wb_prio_pc_ce", {29'd0, state, pc_ce}, {28'd0, 3'd4, 1'b1});
        next();
        #1;
        chk("wb_prio_idle", {29'd0, state}, 32'd0);
        run = 1'b1;
        dbg_mode = 1'b0;
        repeat (3) next();
        run = 1'b0;
        #1;
        chk("exec_run_drop_acc", {28'd0, state, acc_we}, {28'd0, 3'd3, 1'b1});
        next();
        #1;
        chk("exec_run_drop_wb", {28'd0, state, pc_ce}, {28'd0, 3'd4, 1'b1});
        next();
        #1;
        chk("exec_run_drop_idle", {29'd0, state}, 32'd0);

        // Reset in EXEC aborts in the same cycle.
        do_reset();
        {run, mem_ready, load_req, store_req} = 4'b1111;
        repeat (7) next();
        #1;
        chk("pre_rst_exec", {12'd0, state, acc_we, instr_cnt}, {12'd0, 3'd3, 1'b1, 16'd1});
        rst = 1'b1;
        #1;
        chk("rst_in_exec", {12'd0, state, acc_we, instr_cnt}, 32'd0);
        rst = 1'b0;

        // Saturation: ten instructions on a 3-bit counter stop at 7.
        do_reset();
        {run, mem_ready, load_req, store_req} = 4'b1111;
        repeat (41) next();
        #1;
        chk("main_cnt_10", {16'd0, instr_cnt}, 32'd10);
        chk("small_cnt_sat", {29'd0, s_instr_cnt}, 32'd7);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
